// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns (bits a..g),
// digit strobe codes, the conversion FSM state type and the default stability window.
package seg_pkg;

    localparam int unsigned StableCyclesDefault = 4;

    localparam logic [6:0] Seg0 = 7'b1111110;
    localparam logic [6:0] Seg1 = 7'b0110000;
    localparam logic [6:0] Seg2 = 7'b1101101;
    localparam logic [6:0] Seg3 = 7'b1111001;
    localparam logic [6:0] Seg4 = 7'b0110011;
    localparam logic [6:0] Seg5 = 7'b1011011;
    localparam logic [6:0] Seg6 = 7'b1011111;
    localparam logic [6:0] Seg7 = 7'b1110000;
    localparam logic [6:0] Seg8 = 7'b1111111;
    localparam logic [6:0] Seg9 = 7'b1111011;

    localparam logic [1:0] ConTens = 2'b10;
    localparam logic [1:0] ConOnes = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of a seven-segment pattern (a..g, dp excluded) to a BCD digit;
// valid is low for any pattern that is not one of the ten digits.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            Seg0:    digit = 4'd0;
            Seg1:    digit = 4'd1;
            Seg2:    digit = 4'd2;
            Seg3:    digit = 4'd3;
            Seg4:    digit = 4'd4;
            Seg5:    digit = 4'd5;
            Seg6:    digit = 4'd6;
            Seg7:    digit = 4'd7;
            Seg8:    digit = 4'd8;
            Seg9:    digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Debounces a multiplexed two-digit seven-segment scan, keeps the last good tens/ones
// digits and converts them to binary with a 7-step shift-and-subtract-3 engine.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = StableCyclesDefault
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] digit_seg,
    input  logic [1:0] digit_con,
    output logic [3:0] ten_bcd,
    output logic [3:0] one_bcd,
    output logic [6:0] value,
    output logic       value_valid,
    output logic       dec_err
);

    localparam int unsigned   CntW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

    logic [7:0]      seg_q;
    logic [1:0]      con_q;
    logic [9:0]      prev_q;
    logic [CntW-1:0] stab_q, stab_d;
    logic            same, accept, digit_strobe;
    logic [3:0]      dec_digit;
    logic            dec_valid;

    logic [3:0]      ten_slot_q, ten_slot_d, one_slot_q, one_slot_d;
    logic            tens_ok_q, tens_ok_d, ones_ok_q, ones_ok_d;
    logic            pending_q, pending_d;

    state_e          state_q, state_d;
    logic            load, shift_en, last_shift;
    logic [14:0]     sr_q, sr_shift;
    logic [2:0]      shcnt_q;
    logic [3:0]      snap_ten_q, snap_one_q;
    logic [3:0]      ten_q, one_q;
    logic [6:0]      value_q;

    // Input sampling and stability tracking
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            seg_q  <= '0;
            con_q  <= '0;
            prev_q <= '0;
            stab_q <= '0;
        end else begin
            seg_q  <= digit_seg;
            con_q  <= digit_con;
            prev_q <= {con_q, seg_q};
            stab_q <= stab_d;
        end
    end

    always_comb begin
        same   = ({con_q, seg_q} == prev_q);
        stab_d = '0;
        if (same) begin
            stab_d = (stab_q == CntMax) ? stab_q : stab_q + 1'b1;
        end
        // Fires only on the step into saturation, so a held sample is taken once.
        accept       = same && (stab_q == CntMax - 1'b1);
        digit_strobe = accept && ((con_q == ConTens) || (con_q == ConOnes));
        dec_err      = digit_strobe && !dec_valid;
    end

    seg7_to_bcd u_seg7_to_bcd (
        .seg   (seg_q[7:1]),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    always_comb begin
        ten_slot_d = ten_slot_q;
        one_slot_d = one_slot_q;
        tens_ok_d  = tens_ok_q;
        ones_ok_d  = ones_ok_q;
        pending_d  = pending_q;
        if (load) begin
            pending_d = 1'b0;
        end
        if (digit_strobe) begin
            if (dec_valid) begin
                if (con_q == ConTens) begin
                    ten_slot_d = dec_digit;
                    tens_ok_d  = 1'b1;
                end else begin
                    one_slot_d = dec_digit;
                    ones_ok_d  = 1'b1;
                end
                // A fresh write wins over the clear from a same-cycle load.
                if (tens_ok_d && ones_ok_d) begin
                    pending_d = 1'b1;
                end
            end else if (con_q == ConTens) begin
                tens_ok_d = 1'b0;
            end else begin
                ones_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ten_slot_q <= '0;
            one_slot_q <= '0;
            tens_ok_q  <= 1'b0;
            ones_ok_q  <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            ten_slot_q <= ten_slot_d;
            one_slot_q <= one_slot_d;
            tens_ok_q  <= tens_ok_d;
            ones_ok_q  <= ones_ok_d;
            pending_q  <= pending_d;
        end
    end

    // Conversion FSM
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pending_q) state_d = StShift;
            StShift: if (shcnt_q == 3'd6) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load        = (state_q == StIdle) && pending_q;
        shift_en    = (state_q == StShift);
        last_shift  = shift_en && (shcnt_q == 3'd6);
        value_valid = (state_q == StDone);
    end

    always_comb begin
        sr_shift = {1'b0, sr_q[14:1]};
        if (sr_shift[14:11] >= 4'd8) sr_shift[14:11] = sr_shift[14:11] - 4'd3;
        if (sr_shift[10:7] >= 4'd8)  sr_shift[10:7]  = sr_shift[10:7] - 4'd3;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sr_q       <= '0;
            shcnt_q    <= '0;
            snap_ten_q <= '0;
            snap_one_q <= '0;
            ten_q      <= '0;
            one_q      <= '0;
            value_q    <= '0;
        end else begin
            if (load) begin
                sr_q       <= {ten_slot_q, one_slot_q, 7'b0};
                shcnt_q    <= '0;
                snap_ten_q <= ten_slot_q;
                snap_one_q <= one_slot_q;
            end else if (shift_en) begin
                sr_q    <= sr_shift;
                shcnt_q <= shcnt_q + 3'd1;
            end
            // Results land with the final shift so they are visible in the DONE cycle.
            if (last_shift) begin
                value_q <= sr_shift[6:0];
                ten_q   <= snap_ten_q;
                one_q   <= snap_one_q;
            end
        end
    end

    assign value   = value_q;
    assign ten_bcd = ten_q;
    assign one_bcd = one_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length/slot reference model predicts
// conversions and decode errors; a monitor pops and checks them as the DUT reports.
module tb_seg_scan_decoder;

    localparam int Stable = 4;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [7:0] digit_seg = '0;
    logic [1:0] digit_con = '0;
    logic [3:0] ten_bcd, one_bcd;
    logic [6:0] value;
    logic       value_valid, dec_err;

    seg_scan_decoder #(
        .STABLE_CYCLES (Stable)
    ) dut (
        .clk         (clk),
        .res         (res),
        .digit_seg   (digit_seg),
        .digit_con   (digit_con),
        .ten_bcd     (ten_bcd),
        .one_bcd     (one_bcd),
        .value       (value),
        .value_valid (value_valid),
        .dec_err     (dec_err)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) begin
        if (!res) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int value;
        int ten;
        int one;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         dec_q[$];
    logic [9:0] hist[$];
    int         m_ten, m_one, m_free;
    bit         m_tok, m_ook, m_pend;
    int         held_val, held_ten, held_one;
    int         vectors = 0;
    int         miscompares = 0;

    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (pat[i] == s) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        logic [6:0] p;
        logic       dp;
        p  = pat[d];
        dp = 1'($urandom_range(0, 1));
        return {p, dp};
    endfunction

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Called at the falling edge with cyc == c: the input becomes registered sample c+1,
    // and the model resolves what happens at rising edge c+2.
    task automatic model_step(input logic [1:0] con, input logic [7:0] seg);
        int         e;
        int         run;
        int         d;
        logic [9:0] s;
        e = cyc + 2;
        hist.push_back({con, seg});
        if (hist.size() > Stable + 2) void'(hist.pop_front());
        if (m_pend && e >= m_free) begin
            exp_q.push_back('{m_ten * 10 + m_one, m_ten, m_one, e + 7});
            m_pend = 1'b0;
            m_free = e + 9;
        end
        run = 0;
        s   = hist[hist.size() - 1];
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == s) run++;
            else break;
        end
        if (run == Stable + 1 && (s[9:8] == 2'b10 || s[9:8] == 2'b01)) begin
            d = lookup(s[7:1]);
            if (d < 0) begin
                dec_q.push_back(cyc + 1);
                if (s[9:8] == 2'b10) m_tok = 1'b0;
                else                 m_ook = 1'b0;
            end else begin
                if (s[9:8] == 2'b10) begin m_ten = d; m_tok = 1'b1; end
                else                 begin m_one = d; m_ook = 1'b1; end
                if (m_tok && m_ook) m_pend = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic [1:0] con, input logic [7:0] seg, input int n);
        repeat (n) begin
            @(negedge clk);
            digit_con = con;
            digit_seg = seg;
            model_step(con, seg);
        end
    endtask

    task automatic apply_reset(input int n_low);
        @(negedge clk);
        res       = 1'b0;
        digit_con = '0;
        digit_seg = '0;
        #1;
        check("reset value", value, 0);
        check("reset ten_bcd", ten_bcd, 0);
        check("reset one_bcd", one_bcd, 0);
        check("reset value_valid", value_valid, 0);
        check("reset dec_err", dec_err, 0);
        exp_q.delete();
        dec_q.delete();
        hist.delete();
        m_ten = 0; m_one = 0; m_tok = 0; m_ook = 0; m_pend = 0; m_free = 0;
        held_val = 0; held_ten = 0; held_one = 0;
        repeat (n_low) @(negedge clk);
        hist.push_back(10'd0);
        hist.push_back(10'd0);
        res = 1'b1;
        model_step(2'b00, 8'h00);
    endtask

    initial begin
        exp_t e;
        bit   exp_dec;
        forever begin
            @(posedge clk);
            #2;
            if (res) begin
                if (value_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected value_valid", value_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("value_valid cycle", cyc, e.cyc);
                        held_val = e.value;
                        held_ten = e.ten;
                        held_one = e.one;
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    check("missed value_valid", 0, e.value + 1000);
                end
                exp_dec = (dec_q.size() > 0 && dec_q[0] == cyc);
                if (exp_dec) void'(dec_q.pop_front());
                check("dec_err", dec_err, int'(exp_dec));
                check("value", value, held_val);
                check("ten_bcd", ten_bcd, held_ten);
                check("one_bcd", one_bcd, held_one);
            end
        end
    end

    initial begin
        logic [1:0] con;
        logic [7:0] seg;
        apply_reset(3);

        drive(2'b10, 8'b0110_0110, 6);           // tens 4
        drive(2'b01, 8'b1101_1010, 6);           // ones 2 -> 42
        drive(2'b00, 8'h00, 14);

        drive(2'b10, seg_of(9), 6);
        drive(2'b01, seg_of(9), 6);              // 99
        drive(2'b00, 8'h00, 14);
        drive(2'b10, seg_of(0), 6);              // 09
        drive(2'b01, seg_of(0), 6);              // 00
        drive(2'b00, 8'h00, 14);

        drive(2'b01, 8'h00, 6);                  // bad pattern on ones
        drive(2'b00, 8'h00, 14);

        apply_reset(2);
        drive(2'b10, seg_of(4), 6);
        drive(2'b01, seg_of(8), 2);              // too short to be accepted
        drive(2'b01, seg_of(2), 6);
        drive(2'b00, 8'h00, 14);

        apply_reset(2);
        drive(2'b10, seg_of(4), 6);
        drive(2'b01, seg_of(2), 6);
        drive(2'b01, seg_of(3), 6);              // lands while 42 is converting
        drive(2'b00, 8'h00, 25);

        drive(2'b10, seg_of(7), 6);
        drive(2'b01, seg_of(6), 6);
        drive(2'b00, 8'h00, 4);                  // conversion now shifting
        apply_reset(2);
        drive(2'b10, seg_of(5), 8);
        drive(2'b00, 8'h00, 20);
        drive(2'b01, seg_of(1), 6);              // 51 once both are back
        drive(2'b00, 8'h00, 15);

        for (int i = 0; i < 250; i++) begin
            con = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) seg = 8'($urandom);
            else                           seg = seg_of($urandom_range(0, 9));
            drive(con, seg, $urandom_range(1, 8));
        end

        drive(2'b00, 8'h00, 30);
        check("scoreboard drained", exp_q.size() + dec_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
